ram_wr_arbiter: RTL
===================

Name: ram_wr_arbiter

Overview:
- Shares the single synchronous write port of the team's multi-port RAM (two async/sync read ports, one write port) between NUM_REQ independent writers, using round-robin arbitration.
- Sequences a full-array clear after reset and on request, so that read ports never return uninitialised contents.
- Sits directly in front of the RAM. Its w_addr/w_data/write_enable outputs drive the RAM write port one-to-one. Read ports are untouched.

Parameters:
- ADDR_WIDTH, 3, RAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM word width.
- NUM_REQ, 3, number of write requesters (2..8).
- CLEAR_VALUE, 0, word written to every entry during clear.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear_start  in  1  pulse; starts a full clear when in RUN.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_REQ*DATA_WIDTH  packed data, same packing.
- req_ready  out  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] && req_ready[i].
- w_addr  out  ADDR_WIDTH  to RAM w_addr.
- w_data  out  DATA_WIDTH  to RAM w_data.
- write_enable  out  1  to RAM write_enable.
- grant_id  out  $clog2(NUM_REQ)  index of the last accepted requester (registered).
- init_done  out  1  high while in RUN.

Behaviour:
- Reset (async, rst=1):
  - state=CLEAR, clear counter=0, rr pointer=0.
  - write_enable=0, w_addr=0, w_data=0, grant_id=0, init_done=0.
  - req_ready=0 while rst is high.
- Two states: CLEAR and RUN.
- CLEAR:
  - Every cycle: write_enable=1, w_addr=counter, w_data=CLEAR_VALUE (registered outputs). Counter increments.
  - After the entry at address 2**ADDR_WIDTH-1 is issued, go to RUN. Exactly 2**ADDR_WIDTH write cycles; counter wraps to 0.
  - req_ready=0 throughout. clear_start is ignored.
  - init_done=0; it rises on the first RUN cycle.
- RUN:
  - Grant is combinational. Scan from rr pointer upward modulo NUM_REQ; the first i with req_valid[i]=1 gets req_ready[i]=1. At most one ready bit is set. req_ready may depend on req_valid in the same cycle.
  - On a handshake in cycle N:
    - In cycle N+1: write_enable=1, w_addr=req_addr[i], w_data=req_data[i], grant_id=i.
    - RAM contents update at the end of cycle N+1.
    - rr pointer becomes (i+1) mod NUM_REQ.
  - No handshake in cycle N: write_enable=0 in N+1; w_addr/w_data/grant_id hold; pointer holds.
  - Throughput: one write per cycle; back-to-back grants permitted.
- clear_start in RUN:
  - Takes priority over requests in the same cycle: req_ready=0 in that cycle.
  - Next state is CLEAR with counter=0; init_done drops the next cycle.
  - A write already registered from the previous cycle still completes.
- A requester holds req_valid, req_addr and req_data stable until accepted. The arbiter does not check this.
- Same address from different requesters in consecutive cycles: writes land in grant order; the last write wins.
- Reset mid-clear or mid-write:
  - Outputs drop immediately.
  - The in-flight write is lost; RAM contents are undefined until the new clear completes.

Test Plan:
- Reset release, no requests (AW=3) -> write_enable high for 8 cycles, w_addr 0..7, w_data 0; init_done rises on cycle 9. Read ports then return 0 for every address.
- RUN, only req 1 valid, addr 5, data 8'hA7 -> req_ready=3'b010 in the same cycle; next cycle write_enable=1, w_addr=5, w_data=A7, grant_id=1; RAM[5]=A7 afterwards.
- All three valid continuously, pointer 0 -> grant order 0,1,2,0,1,2; write_enable high every cycle after the first grant; no requester is skipped.
- Req 0 and req 2 valid, pointer 1 -> req 2 granted first, then req 0; pointer ends at 1.
- clear_start in the same cycle as req 0 valid -> req_ready=0; 8 clear writes follow; req 0 is granted on the first RUN cycle after clear.
- rst asserted during clear at counter=4 -> outputs zero immediately; after release the clear restarts at address 0 and runs a full 8 cycles.

Source files
------------

// File: rtl/ram_wr_arbiter.sv
// rtl/ram_wr_arbiter.sv - round-robin write-port arbiter with post-reset RAM clear
//
// Purpose: shares the single RAM write port between NUM_REQ writers and
// clears the whole array after reset or on clear_start.
// Ports:
//   clk, rst            clock, async active-high reset
//   clear_start         pulse, restarts a full clear while running
//   req_valid/addr/data per-requester write request (packed, i-th slice)
//   req_ready           one-hot combinational grant
//   w_addr/w_data/write_enable  registered RAM write port
//   grant_id            index of the last accepted requester
//   init_done           high while running (clear finished)
module ram_wr_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 3,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear_start,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [ADDR_WIDTH-1:0]            w_addr,
  output logic [DATA_WIDTH-1:0]            w_data,
  output logic                             write_enable,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  output logic                             init_done
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  // Extra top bit marks "all entries issued"; low bits are the clear address.
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [GW-1:0]         rr_q, rr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [GW-1:0]         grant_id_q, grant_id_d;

  logic                  gnt_valid;
  logic [GW-1:0]         gnt_idx;
  logic [NUM_REQ-1:0]    req_ready_c;
  int                    scan_idx;

  // Round-robin scan starting at rr_q; clear_start suppresses any grant.
  always_comb begin
    gnt_valid   = 1'b0;
    gnt_idx     = '0;
    req_ready_c = '0;
    scan_idx    = 0;
    if (state_q == ST_RUN && !clear_start) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = int'(rr_q) + k;
        if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
        if (!gnt_valid && req_valid[scan_idx]) begin
          gnt_valid = 1'b1;
          gnt_idx   = GW'(scan_idx);
        end
      end
    end
    if (gnt_valid) req_ready_c[gnt_idx] = 1'b1;
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      rr_q       <= '0;
      we_q       <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      we_q       <= we_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      grant_id_q <= grant_id_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    case (state_q)
      ST_CLEAR: begin
        // The last clear write is on the bus while cnt_q has wrapped into
        // its top bit, so RUN starts on the cycle after that write.
        if (cnt_q[ADDR_WIDTH]) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + (ADDR_WIDTH+1)'(1);
        end
      end
      default: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
    if (gnt_valid) begin
      rr_d = (gnt_idx == GW'(NUM_REQ-1)) ? '0 : gnt_idx + GW'(1);
    end
  end

  // Output logic: next values for the registered write port.
  always_comb begin
    we_d       = 1'b0;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    grant_id_d = grant_id_q;
    if (state_q == ST_CLEAR) begin
      if (!cnt_q[ADDR_WIDTH]) begin
        we_d     = 1'b1;
        w_addr_d = cnt_q[ADDR_WIDTH-1:0];
        w_data_d = CLEAR_VALUE;
      end
    end else if (gnt_valid) begin
      we_d       = 1'b1;
      w_addr_d   = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      w_data_d   = req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      grant_id_d = gnt_idx;
    end
  end

  assign req_ready    = req_ready_c;
  assign w_addr       = w_addr_q;
  assign w_data       = w_data_q;
  assign write_enable = we_q;
  assign grant_id     = grant_id_q;
  assign init_done    = (state_q == ST_RUN);

endmodule
